// File: rtl/ads_serial_rx.sv
// Multi-lane capture front end for ADS16xx-class serial ADCs: synchronises SCLK/DRDY/DOUT,
// sequences the START pin, discards settling frames and deframes DW-bit words per lane.
`timescale 1ns/1ps
module ads_serial_rx #(
    parameter int DW        = 24,
    parameter int NCH       = 1,
    parameter int DISCARD   = 2,
    parameter int START_LOW = 16
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              en,
    output logic              start,
    input  logic              sclk,
    input  logic              drdy,
    input  logic [NCH-1:0]    dout,
    output logic [NCH*DW-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CW  = $clog2(DW + 1);
    localparam int TW  = (START_LOW > 1) ? $clog2(START_LOW) : 1;
    localparam int DCW = (DISCARD > 1) ? $clog2(DISCARD) : 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] TOGGLE    = 2'd1;
    localparam logic [1:0] WAIT_LOCK = 2'd2;
    localparam logic [1:0] CAPTURE   = 2'd3;

    logic           sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic           drdy_s1_q, drdy_s2_q, drdy_h_q;
    logic [NCH-1:0] dout_s1_q, dout_s2_q;

    logic [1:0]     state_q, state_d;
    logic [TW-1:0]  tog_cnt_q, tog_cnt_d;
    logic [DCW-1:0] disc_cnt_q, disc_cnt_d;
    logic           start_q, start_d;

    logic [CW-1:0]  cnt_q, cnt_d;
    logic           armed_q, armed_d;
    logic           done_q, done_d;
    logic           ferr_q, ferr_d;
    logic           shift_en;
    logic signed [DW-1:0] shift_q [NCH];

    logic [NCH*DW-1:0] m_data_q, frame_w;
    logic           m_valid_q, m_valid_d;
    logic           ovr_q, ovr_d;
    logic           load;

    logic           drdy_rise, sclk_fall, active;

    // Synchroniser: dout rides the same two-flop depth as sclk so each bit is sampled
    // in the same aclk cycle its falling edge is seen.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_h_q  <= 1'b0;
            drdy_s1_q <= 1'b0;
            drdy_s2_q <= 1'b0;
            drdy_h_q  <= 1'b0;
            dout_s1_q <= '0;
            dout_s2_q <= '0;
        end else begin
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_h_q  <= sclk_s2_q;
            drdy_s1_q <= drdy;
            drdy_s2_q <= drdy_s1_q;
            drdy_h_q  <= drdy_s2_q;
            dout_s1_q <= dout;
            dout_s2_q <= dout_s1_q;
        end
    end

    assign drdy_rise = drdy_s2_q & ~drdy_h_q;
    assign sclk_fall = ~sclk_s2_q & sclk_h_q;
    assign active    = en && ((state_q == WAIT_LOCK) || (state_q == CAPTURE));

    always_comb begin
        state_d    = state_q;
        tog_cnt_d  = tog_cnt_q;
        disc_cnt_d = disc_cnt_q;
        if (!en) begin
            state_d    = IDLE;
            tog_cnt_d  = '0;
            disc_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = TOGGLE;
                    tog_cnt_d  = '0;
                    disc_cnt_d = '0;
                end
                TOGGLE: begin
                    if (tog_cnt_q == TW'(START_LOW - 1))
                        state_d = (DISCARD == 0) ? CAPTURE : WAIT_LOCK;
                    else
                        tog_cnt_d = tog_cnt_q + TW'(1);
                end
                WAIT_LOCK: begin
                    if (done_q) begin
                        if (disc_cnt_q == DCW'(DISCARD - 1))
                            state_d = CAPTURE;
                        else
                            disc_cnt_d = disc_cnt_q + DCW'(1);
                    end
                end
                CAPTURE: state_d = CAPTURE;
                default: state_d = IDLE;
            endcase
        end
        start_d = (state_d == WAIT_LOCK) || (state_d == CAPTURE);
    end

    // Deframer: a DRDY rise takes priority over a coincident SCLK fall.
    always_comb begin
        cnt_d    = cnt_q;
        armed_d  = armed_q;
        done_d   = 1'b0;
        ferr_d   = 1'b0;
        shift_en = 1'b0;
        if (!active) begin
            cnt_d   = '0;
            armed_d = 1'b0;
        end else if (drdy_rise) begin
            ferr_d  = armed_q && (cnt_q != '0);
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (sclk_fall && armed_q) begin
            shift_en = 1'b1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(DW - 1)) begin
                armed_d = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (shift_en) begin
            for (int k = 0; k < NCH; k++)
                shift_q[k] <= {shift_q[k][DW-2:0], dout_s2_q[k]};
        end
    end

    always_comb begin
        frame_w = '0;
        for (int k = 0; k < NCH; k++)
            frame_w[k*DW +: DW] = shift_q[k];
    end

    assign load      = done_q && (state_q == CAPTURE);
    assign m_valid_d = load | (m_valid_q & ~m_ready);
    assign ovr_d     = load & m_valid_q & ~m_ready;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= IDLE;
            tog_cnt_q  <= '0;
            disc_cnt_q <= '0;
            start_q    <= 1'b0;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            m_valid_q  <= 1'b0;
            ovr_q      <= 1'b0;
            m_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            tog_cnt_q  <= tog_cnt_d;
            disc_cnt_q <= disc_cnt_d;
            start_q    <= start_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            m_valid_q  <= m_valid_d;
            ovr_q      <= ovr_d;
            if (load)
                m_data_q <= frame_w;
        end
    end

    assign start     = start_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule
